// File: rtl/com_pkg.sv
// rtl/com_pkg.sv - shared decode/execute types and the register-pack helper
package com_pkg;

  localparam int NUM_ARCH_REGS = 16;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_BRANCH,
    CLS_LOAD,
    CLS_STORE,
    ILLEGAL
  } inst_class_t;

  typedef struct packed {
    logic       used;
    logic [3:0] sel;
  } decode_reg_t;

  typedef struct packed {
    inst_class_t inst_class;
    logic [3:0]  func;
    logic        illegal;
    decode_reg_t rs1;
    decode_reg_t rs2;
    decode_reg_t rd;
    logic        uses_pc;
    logic        has_imm;
    logic [31:0] imm;
  } decode_instruction_2_t;

  typedef struct packed {
    logic [4:0]  rs;
    logic [31:0] val;
    logic        valid;
    logic        predetermined;
  } reg_pack_t;

  typedef struct packed {
    inst_class_t inst_class;
    logic [3:0]  func;
    logic        illegal;
    reg_pack_t   rs1;
    reg_pack_t   rs2;
    reg_pack_t   rs3;
    reg_pack_t   rd;
  } instruction_pack_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] target;
  } flush_t;

  // A predetermined operand (PC or immediate) is always valid regardless of the register use bit.
  function automatic reg_pack_t pack_reg(decode_reg_t r, logic [31:0] val, logic pre);
    reg_pack_t p;
    p.rs            = {1'b0, r.sel};
    p.val           = val;
    p.valid         = pre | r.used;
    p.predetermined = pre;
    return p;
  endfunction

endpackage

// File: rtl/opf_scoreboard.sv
// rtl/opf_scoreboard.sv - register pending vector with RAW/WAW queries; bypass under OPF_BYPASS_EN
module opf_scoreboard
  import com_pkg::*;
#(
  parameter int NUM_REGS = NUM_ARCH_REGS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        set_en,
  input  logic [3:0]  set_sel,
  input  logic        clr_en,
  input  logic        clr_kill,
  input  logic [3:0]  clr_sel,
  input  logic        rel_en,
  input  logic [3:0]  rel_sel,
  input  decode_reg_t src1,
  input  decode_reg_t src2,
  input  decode_reg_t dst,
  output logic        stall1,
  output logic        stall2,
  output logic        bypass1,
  output logic        bypass2,
  output logic        waw
);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_next;

  // Clears are applied after the set so a same-cycle collision resolves to cleared.
  always_comb begin
    pending_next = pending;
    if (set_en) pending_next[set_sel] = 1'b1;
    if (clr_en) pending_next[clr_sel] = 1'b0;
    if (rel_en) pending_next[rel_sel] = 1'b0;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_next;
  end

`ifdef OPF_BYPASS_EN
  assign bypass1 = clr_en & ~clr_kill & src1.used & (src1.sel != 4'd0) & (clr_sel == src1.sel);
  assign bypass2 = clr_en & ~clr_kill & src2.used & (src2.sel != 4'd0) & (clr_sel == src2.sel);
`else
  logic unused_clr_kill;
  assign unused_clr_kill = clr_kill;
  assign bypass1 = 1'b0;
  assign bypass2 = 1'b0;
`endif

  assign stall1 = src1.used & (src1.sel != 4'd0) & pending[src1.sel] & ~bypass1;
  assign stall2 = src2.used & (src2.sel != 4'd0) & pending[src2.sel] & ~bypass2;
  assign waw    = dst.used  & (dst.sel  != 4'd0) & pending[dst.sel];

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - operand fetch stage between decode and execute; OPF_BYPASS_EN enables writeback bypass
module operand_fetch
  import com_pkg::*;
#(
  parameter int NUM_REGS = NUM_ARCH_REGS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dec_valid,
  output logic                  dec_ready,
  input  decode_instruction_2_t dec_inst,
  input  logic [31:0]           dec_pc,
  output logic [3:0]            rf_raddr1,
  output logic [3:0]            rf_raddr2,
  input  logic [31:0]           rf_rdata1,
  input  logic [31:0]           rf_rdata2,
  input  logic                  wb_valid,
  input  logic                  wb_kill,
  input  logic [3:0]            wb_rd,
  input  logic [31:0]           wb_data,
  output logic                  op_valid,
  input  logic                  op_ready,
  output instruction_pack_t     op_inst,
  output logic [31:0]           op_pc,
  input  flush_t                flush
);

  logic              stall1, stall2, bypass1, bypass2, waw;
  logic              accept, set_en, rel_en;
  logic [31:0]       val1, val2;
  instruction_pack_t pk;
  logic              unused_flush_target;

  assign unused_flush_target = ^flush.target;

  assign rf_raddr1 = dec_inst.rs1.sel;
  assign rf_raddr2 = dec_inst.rs2.sel;

  assign dec_ready = ~flush.valid & ~(op_valid & ~op_ready)
                   & (dec_inst.illegal | ~(stall1 | stall2 | waw));
  assign accept    = dec_valid & dec_ready;
  assign set_en    = accept & dec_inst.rd.used & (dec_inst.rd.sel != 4'd0) & ~dec_inst.illegal;

  // A flushed entry never reaches execute, so its reservation is returned here.
  assign rel_en = flush.valid & op_valid & ~op_inst.illegal & op_inst.rd.valid
                & (op_inst.rd.rs[3:0] != 4'd0);

  opf_scoreboard #(.NUM_REGS(NUM_REGS)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (set_en),
    .set_sel  (dec_inst.rd.sel),
    .clr_en   (wb_valid),
    .clr_kill (wb_kill),
    .clr_sel  (wb_rd),
    .rel_en   (rel_en),
    .rel_sel  (op_inst.rd.rs[3:0]),
    .src1     (dec_inst.rs1),
    .src2     (dec_inst.rs2),
    .dst      (dec_inst.rd),
    .stall1   (stall1),
    .stall2   (stall2),
    .bypass1  (bypass1),
    .bypass2  (bypass2),
    .waw      (waw)
  );

  always_comb begin
    val1 = (dec_inst.rs1.sel == 4'd0) ? 32'd0 : rf_rdata1;
    val2 = (dec_inst.rs2.sel == 4'd0) ? 32'd0 : rf_rdata2;
    if (bypass1) val1 = wb_data;
    if (bypass2) val2 = wb_data;

    pk            = '0;
    pk.inst_class = dec_inst.illegal ? ILLEGAL : dec_inst.inst_class;
    pk.func       = dec_inst.func;
    pk.illegal    = dec_inst.illegal;
    pk.rs1        = dec_inst.uses_pc ? pack_reg(dec_inst.rs1, dec_pc, 1'b1)
                                     : pack_reg(dec_inst.rs1, val1, 1'b0);
    pk.rs2        = dec_inst.has_imm ? pack_reg(dec_inst.rs2, dec_inst.imm, 1'b1)
                                     : pack_reg(dec_inst.rs2, val2, 1'b0);
    pk.rd         = pack_reg(dec_inst.rd, 32'd0, 1'b0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid <= 1'b0;
      op_inst  <= '0;
      op_pc    <= '0;
    end else if (flush.valid) begin
      op_valid <= 1'b0;
    end else if (accept) begin
      op_valid <= 1'b1;
      op_inst  <= pk;
      op_pc    <= dec_pc;
    end else if (op_ready) begin
      op_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - directed scoreboard bench for operand_fetch
module tb_operand_fetch;
  import com_pkg::*;

  logic                  clk;
  logic                  rst_n;
  logic                  dec_valid;
  logic                  dec_ready;
  decode_instruction_2_t dec_inst;
  logic [31:0]           dec_pc;
  logic [3:0]            rf_raddr1, rf_raddr2;
  logic [31:0]           rf_rdata1, rf_rdata2;
  logic                  wb_valid, wb_kill;
  logic [3:0]            wb_rd;
  logic [31:0]           wb_data;
  logic                  op_valid, op_ready;
  instruction_pack_t     op_inst;
  logic [31:0]           op_pc;
  flush_t                flush;

  typedef struct {
    instruction_pack_t inst;
    logic [31:0]       pc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] rf [16];

  operand_fetch dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dec_valid (dec_valid),
    .dec_ready (dec_ready),
    .dec_inst  (dec_inst),
    .dec_pc    (dec_pc),
    .rf_raddr1 (rf_raddr1),
    .rf_raddr2 (rf_raddr2),
    .rf_rdata1 (rf_rdata1),
    .rf_rdata2 (rf_rdata2),
    .wb_valid  (wb_valid),
    .wb_kill   (wb_kill),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_inst   (op_inst),
    .op_pc     (op_pc),
    .flush     (flush)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1);
  end

  // Register file model: written at the writeback edge, killed writebacks carry no data.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) rf[i] <= 32'd0;
      rf[1] <= 32'd5;
      rf[2] <= 32'd7;
    end else if (wb_valid && !wb_kill && wb_rd != 4'd0) begin
      rf[wb_rd] <= wb_data;
    end
  end
  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  task automatic chk(string tag, logic [191:0] obs, logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic reg_pack_t mk_reg(logic [4:0] rs, logic [31:0] val, logic vld, logic pre);
    reg_pack_t r;
    r.rs = rs; r.val = val; r.valid = vld; r.predetermined = pre;
    return r;
  endfunction

  function automatic decode_instruction_2_t mk_inst(inst_class_t cls, logic [3:0] func,
      logic rd_u, logic [3:0] rd, logic s1_u, logic [3:0] s1, logic s2_u, logic [3:0] s2,
      logic upc, logic himm, logic [31:0] imm, logic ill);
    decode_instruction_2_t d;
    d.inst_class = cls; d.func = func; d.illegal = ill;
    d.rd.used = rd_u;   d.rd.sel = rd;
    d.rs1.used = s1_u;  d.rs1.sel = s1;
    d.rs2.used = s2_u;  d.rs2.sel = s2;
    d.uses_pc = upc; d.has_imm = himm; d.imm = imm;
    return d;
  endfunction

  function automatic decode_instruction_2_t add_inst(logic [3:0] rd, logic [3:0] s1, logic [3:0] s2);
    return mk_inst(CLS_ALU, 4'd0, 1'b1, rd, 1'b1, s1, 1'b1, s2, 1'b0, 1'b0, 32'd0, 1'b0);
  endfunction

  function automatic instruction_pack_t exp_pack(inst_class_t cls, logic [3:0] func, logic ill,
      reg_pack_t r1, reg_pack_t r2, reg_pack_t rd);
    instruction_pack_t p;
    p.inst_class = cls; p.func = func; p.illegal = ill;
    p.rs1 = r1; p.rs2 = r2; p.rs3 = '0; p.rd = rd;
    return p;
  endfunction

  task automatic push(instruction_pack_t i, logic [31:0] pc);
    exp_t e;
    e.inst = i; e.pc = pc;
    exp_q.push_back(e);
  endtask

  task automatic offer(decode_instruction_2_t i, logic [31:0] pc);
    dec_valid = 1'b1; dec_inst = i; dec_pc = pc;
    #1;
  endtask

  // Pops the scoreboard on a counted handshake, then advances to 1 time unit after the edge.
  task automatic clk_step();
    exp_t e;
    #1;
    if (op_valid && op_ready && !flush.valid) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_output: observed pc %0h expected no output", op_pc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("op_inst", op_inst, e.inst);
        chk("op_pc", op_pc, e.pc);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dec_valid = 1'b0; wb_valid = 1'b0; wb_kill = 1'b0; flush = '0;
  endtask

  initial begin
    rst_n = 1'b0; op_ready = 1'b1; dec_inst = '0; dec_pc = '0;
    wb_rd = '0; wb_data = '0;
    idle();
    #2;
    chk("reset_op_valid", op_valid, 0);
    chk("reset_op_inst", op_inst, 0);
    chk("reset_op_pc", op_pc, 0);
    chk("reset_pending", dut.u_sb.pending, 0);
    chk("reset_dec_ready", dec_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic ADD rd=3 rs1=1 rs2=2
    offer(add_inst(4'd3, 4'd1, 4'd2), 32'h10);
    chk("add_ready", dec_ready, 1);
    push(exp_pack(CLS_ALU, 4'd0, 1'b0, mk_reg(5'd1, 32'd5, 1, 0), mk_reg(5'd2, 32'd7, 1, 0),
                  mk_reg(5'd3, 32'd0, 1, 0)), 32'h10);
    clk_step();
    chk("add_op_valid", op_valid, 1);
    chk("add_pending3", dut.u_sb.pending, 16'h0008);

    // RAW on x3 until writeback
    offer(add_inst(4'd6, 4'd3, 4'd2), 32'h14);
    chk("raw_stall", dec_ready, 0);
    clk_step();
    wb_valid = 1'b1; wb_rd = 4'd3; wb_data = 32'h2A;
    #1;
`ifdef OPF_BYPASS_EN
    chk("raw_bypass_ready", dec_ready, 1);
    push(exp_pack(CLS_ALU, 4'd0, 1'b0, mk_reg(5'd3, 32'h2A, 1, 0), mk_reg(5'd2, 32'd7, 1, 0),
                  mk_reg(5'd6, 32'd0, 1, 0)), 32'h14);
    clk_step();
`else
    chk("raw_nobypass_stall", dec_ready, 0);
    clk_step();
    wb_valid = 1'b0;
    #1;
    chk("raw_nobypass_ready", dec_ready, 1);
    push(exp_pack(CLS_ALU, 4'd0, 1'b0, mk_reg(5'd3, 32'h2A, 1, 0), mk_reg(5'd2, 32'd7, 1, 0),
                  mk_reg(5'd6, 32'd0, 1, 0)), 32'h14);
    clk_step();
`endif
    chk("raw_pending6", dut.u_sb.pending, 16'h0040);
    idle();
    wb_valid = 1'b1; wb_rd = 4'd6; wb_data = 32'h99;
    clk_step();
    chk("wb_release6", dut.u_sb.pending, 16'h0000);
    idle();

    // Branch with PC and immediate operands
    offer(mk_inst(CLS_BRANCH, 4'd1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1, 32'h20, 1'b0),
          32'h100);
    chk("branch_ready", dec_ready, 1);
    push(exp_pack(CLS_BRANCH, 4'd1, 1'b0, mk_reg(5'd0, 32'h100, 1, 1), mk_reg(5'd0, 32'h20, 1, 1),
                  mk_reg(5'd0, 32'd0, 0, 0)), 32'h100);
    clk_step();
    chk("branch_no_reserve", dut.u_sb.pending, 16'h0000);

    // Hold rd=4 entry while execute back-pressures, then flush it
    offer(add_inst(4'd4, 4'd1, 4'd2), 32'h200);
    chk("hold_accept", dec_ready, 1);
    push(exp_pack(CLS_ALU, 4'd0, 1'b0, mk_reg(5'd1, 32'd5, 1, 0), mk_reg(5'd2, 32'd7, 1, 0),
                  mk_reg(5'd4, 32'd0, 1, 0)), 32'h200);
    clk_step();
    op_ready = 1'b0;
    offer(add_inst(4'd7, 4'd1, 4'd2), 32'h204);
    for (int c = 0; c < 3; c++) begin
      chk("hold_dec_ready", dec_ready, 0);
      chk("hold_op_valid", op_valid, 1);
      chk("hold_op_inst", op_inst, exp_q[0].inst);
      chk("hold_op_pc", op_pc, exp_q[0].pc);
      clk_step();
    end
    chk("hold_pending4", dut.u_sb.pending, 16'h0010);
    flush.valid = 1'b1; op_ready = 1'b1;
    #1;
    chk("flush_dec_ready", dec_ready, 0);
    clk_step();
    void'(exp_q.pop_front());
    idle();
    #1;
    chk("flush_op_valid", op_valid, 0);
    chk("flush_pending4", dut.u_sb.pending, 16'h0000);

    // Illegal instruction ignores hazards and reserves nothing
    offer(add_inst(4'd5, 4'd1, 4'd2), 32'h300);
    push(exp_pack(CLS_ALU, 4'd0, 1'b0, mk_reg(5'd1, 32'd5, 1, 0), mk_reg(5'd2, 32'd7, 1, 0),
                  mk_reg(5'd5, 32'd0, 1, 0)), 32'h300);
    clk_step();
    chk("ill_pre_pending5", dut.u_sb.pending, 16'h0020);
    offer(mk_inst(CLS_ALU, 4'd3, 1'b1, 4'd5, 1'b1, 4'd5, 1'b1, 4'd2, 1'b0, 1'b0, 32'd0, 1'b1),
          32'h304);
    chk("ill_ready", dec_ready, 1);
    push(exp_pack(ILLEGAL, 4'd3, 1'b1, mk_reg(5'd5, 32'd0, 1, 0), mk_reg(5'd2, 32'd7, 1, 0),
                  mk_reg(5'd5, 32'd0, 1, 0)), 32'h304);
    clk_step();
    chk("ill_pending5_kept", dut.u_sb.pending, 16'h0020);
    idle();
    wb_valid = 1'b1; wb_kill = 1'b1; wb_rd = 4'd5; wb_data = 32'hDEAD;
    clk_step();
    chk("kill_release5", dut.u_sb.pending, 16'h0000);
    idle();

    // Asynchronous reset while stalled
    offer(add_inst(4'd3, 4'd1, 4'd2), 32'h400);
    push(exp_pack(CLS_ALU, 4'd0, 1'b0, mk_reg(5'd1, 32'd5, 1, 0), mk_reg(5'd2, 32'd7, 1, 0),
                  mk_reg(5'd3, 32'd0, 1, 0)), 32'h400);
    clk_step();
    offer(add_inst(4'd4, 4'd1, 4'd2), 32'h404);
    push(exp_pack(CLS_ALU, 4'd0, 1'b0, mk_reg(5'd1, 32'd5, 1, 0), mk_reg(5'd2, 32'd7, 1, 0),
                  mk_reg(5'd4, 32'd0, 1, 0)), 32'h404);
    clk_step();
    op_ready = 1'b0;
    offer(add_inst(4'd3, 4'd1, 4'd2), 32'h408);
    chk("rst_stall_ready", dec_ready, 0);
    chk("rst_pre_pending", dut.u_sb.pending, 16'h0018);
    clk_step();
    rst_n = 1'b0;
    #1;
    chk("rst_async_pending", dut.u_sb.pending, 16'h0000);
    chk("rst_async_op_valid", op_valid, 0);
    chk("rst_async_op_inst", op_inst, 0);
    exp_q.delete();
    idle();
    op_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rst_release_ready", dec_ready, 1);
    clk_step();
    chk("rst_no_emit", op_valid, 0);
    clk_step();
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch stage between decode and execute. Accepts one `decode_instruction_2_t` per cycle, reads the architectural register file, resolves immediates and PC operands, and checks a register scoreboard for RAW/WAW hazards. It emits a registered `instruction_pack_t` to execute through a valid/ready handshake, and drops in-flight work on `flush_t`.

## Interface
- `NUM_REGS`, 16: architectural registers; `decode_reg_t.sel` is 4 bits; x0 is hardwired zero.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `dec_valid` in 1: decode offers an instruction.
- `dec_ready` out 1: stage accepts this cycle.
- `dec_inst` in `decode_instruction_2_t`: decoded instruction.
- `dec_pc` in 32: PC of `dec_inst`.
- `rf_raddr1`, `rf_raddr2` out 4 each: combinational read addresses (`rs1.sel`, `rs2.sel`).
- `rf_rdata1`, `rf_rdata2` in 32 each: same-cycle read data.
- `wb_valid` in 1: writeback of `wb_rd`; data is written to the regfile at this clock edge.
- `wb_kill` in 1: with `wb_valid`, release the reservation only; no data, no bypass.
- `wb_rd` in 4: writeback register.
- `wb_data` in 32: writeback value.
- `op_valid` out 1: packed instruction available.
- `op_ready` in 1: execute accepts.
- `op_inst` out `instruction_pack_t`: packed instruction.
- `op_pc` out 32: PC of `op_inst`.
- `flush` in `flush_t`: only `flush.valid` is used here.

## Operation
- Scoreboard: `NUM_REGS`-bit `pending` vector; bit 0 is never set.
- Stall (`dec_ready`=0) when any of the following holds:
  - `flush.valid`.
  - Output register full and `op_ready`=0.
  - A used, nonzero `rs1`/`rs2` is pending and not bypassable.
  - A used, nonzero `rd` is pending (WAW).
- Bypassable means `wb_valid & ~wb_kill & wb_rd==sel` in the same cycle.
- Instructions with `illegal`=1 skip all hazard checks, reserve nothing, and pass with `inst_class=ILLEGAL`.
- Operand packing:
  - rs1: `uses_pc` gives `val=dec_pc`, `predetermined=1`, `valid=1`.
  - rs2: `has_imm` gives `val=imm`, `predetermined=1`, `valid=1`.
  - Otherwise `rs={1'b0,sel}`, `val` from bypass, else regfile, else 0 for x0; `valid=used`, `predetermined=0`.
  - rs3: all zero.
  - rd: `rs={1'b0,sel}`, `val=0`, `valid=used`, `predetermined=0`.
  - `func` and `illegal` are copied through.
- On accept, if `rd.used` and `rd.sel!=0` and not illegal, set `pending[rd.sel]`.
- `wb_valid` clears `pending[wb_rd]`. Set and clear of the same bit in one cycle cannot occur because of the WAW stall; if it does, the clear wins.
- Flush:
  - `flush.valid` empties the output register.
  - If the dropped entry had reserved `rd`, its pending bit is cleared in the same edge.
  - The `op_valid`/`op_ready` handshake in a flush cycle does not count; execute ignores it.
  - Pending bits of instructions already in execute/mem are released only via `wb_valid` (`wb_kill` for squashed ones).

## Timing
- Reset values: `op_valid`=0, `op_inst`=0, `op_pc`=0, `pending`=0. `dec_ready` follows combinationally; it is 1 after reset unless `flush.valid`.
- Latency: one cycle from the `dec_valid&dec_ready` edge to `op_valid`=1.
- Throughput: one per cycle while `op_ready`=1 and there are no hazards.
- `op_valid`, `op_inst`, `op_pc` are registered. `dec_ready` is combinational from `op_ready`, `flush`, `wb_*`, `dec_inst`.
- A `rst_n` assertion mid-stall clears everything asynchronously. No instruction is emitted after reset without a new `dec_valid`.
- Output holds stable while `op_valid & ~op_ready`.

## Configuration
- `OPF_BYPASS_EN` defined: same-cycle writeback bypass as above.
- `OPF_BYPASS_EN` undefined: no bypass.
  - A source whose pending bit clears this cycle still stalls one cycle.
  - The operand is read from the regfile the next cycle.
  - `wb_data` is unused.

## Structure
- `com_pkg` additions:
  - constant `NUM_ARCH_REGS=16`.
  - function `pack_reg(decode_reg_t, logic [31:0] val, logic pre)` returning `reg_pack_t`.
- Sub-module `opf_scoreboard`:
  - holds the pending vector, set/clear/flush-release ports, and two hazard query ports.
  - exposes per-source `stall` and `bypass` outputs.

## Test plan
- After reset, ADD rd=3 rs1=1 rs2=2 with `rf_rdata`=5/7 → next cycle `op_valid`=1, `rs1.val`=5, `rs2.val`=7, `rd.valid`=1, `pending[3]`=1.
- Back-to-back ADD rd=3, then ADD rs1=3 → second stalls. Then `wb_valid`, `wb_rd`=3, `wb_data`=0x2A:
  - with `OPF_BYPASS_EN`: accepted that cycle, `rs1.val`=0x2A.
  - without: accepted one cycle later.
- Branch with `uses_pc=1`, `has_imm=1`, `dec_pc`=0x100, `imm`=0x20 → `rs1.val`=0x100, `rs2.val`=0x20, both `predetermined`=1, no rd reservation.
- `op_ready`=0 for 3 cycles with entry rd=4 held → `op_inst` stable, `dec_ready`=0; `flush.valid` pulse → `op_valid`=0 and `pending[4]`=0 next cycle.
- Illegal instruction with rd=5 while `pending[5]`=1 → accepted without stall, `illegal`=1, `pending[5]` unchanged.
- `rst_n` low mid-stall with `pending`=0x0018 → `pending`=0 and `op_valid`=0 immediately; `dec_ready`=1 after release.
